// File: rtl/hlsm_pkg.sv
// Shared definitions for the HLSM Start/Done host: state encoding,
// default widths and the packed operand-triple width helper.
package hlsm_pkg;

  localparam int IN_W_DEF    = 16;
  localparam int Z_W_DEF     = 8;
  localparam int X_W_DEF     = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int MIN_LAT_DEF = 2;
  localparam int TIMEOUT_DEF = 255;

  // 8-bit state register, same layout as the existing kernel-side FSMs
  typedef logic [7:0] state_t;

  localparam state_t ST_IDLE   = 8'd0;
  localparam state_t ST_LAUNCH = 8'd1;
  localparam state_t ST_WAIT   = 8'd2;
  localparam state_t ST_EMIT   = 8'd3;

  // Operands travel through the FIFO as one word {a, b, c}
  function automatic int triple_w(input int in_w);
    return 3 * in_w;
  endfunction

endpackage

// File: rtl/hlsm_host_if.sv
// Operand-in / result-out streams of the HLSM host. The master side is the
// feeder/consumer, the slave side is the host itself.
interface hlsm_host_if
  import hlsm_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int Z_W  = Z_W_DEF,
  parameter int X_W  = X_W_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_a;
  logic [IN_W-1:0] in_b;
  logic [IN_W-1:0] in_c;

  logic            out_valid;
  logic            out_ready;
  logic [Z_W-1:0]  out_z;
  logic [X_W-1:0]  out_x;
  logic            out_err;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_z, out_x, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_z, out_x, out_err
  );

endinterface

// File: rtl/hlsm_op_fifo.sv
// Small synchronous FIFO for operand triples. Pointers carry one extra wrap
// bit so full/empty need no separate occupancy counter.
module hlsm_op_fifo
  import hlsm_pkg::*;
#(
  parameter int W     = triple_w(IN_W_DEF),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; wraps modulo DEPTH through the low AW bits
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge Clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hlsm_host.sv
// Initiator side of the HLSM Start/Done protocol: buffers operand triples,
// launches one kernel run per triple, captures z/x (or flags a timeout) and
// hands the result downstream with valid/ready.
module hlsm_host
  import hlsm_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int Z_W     = Z_W_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MIN_LAT = MIN_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  hlsm_host_if.slave      bus,
  output logic            Start,
  input  logic            Done,
  output logic [IN_W-1:0] a,
  output logic [IN_W-1:0] b,
  output logic [IN_W-1:0] c,
  input  logic [Z_W-1:0]  z,
  input  logic [X_W-1:0]  x,
  output logic            busy,
  output logic [15:0]     run_count
);

  localparam int TW = triple_w(IN_W);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic [Z_W-1:0] res_z;
  logic [X_W-1:0] res_x;
  logic           res_err;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic [TW-1:0]  fifo_dout;

  // Ready depends on full only, so a pop never frees a slot in the same cycle
  assign bus.in_ready = !fifo_full;
  assign fifo_push    = bus.in_valid && bus.in_ready;
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;

  hlsm_op_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bus.in_a, bus.in_b, bus.in_c}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Start decodes straight from state so reset removes it asynchronously
  assign Start         = (state == ST_LAUNCH);
  assign bus.out_valid = (state == ST_EMIT);
  assign bus.out_z     = res_z;
  assign bus.out_x     = res_x;
  assign bus.out_err   = res_err;
  assign busy          = (state != ST_IDLE) || !fifo_empty;

  // Run sequencer: pop -> Start pulse -> wait for Done/timeout -> emit.
  // Done is only honoured in WAIT once MIN_LAT cycles have passed, which
  // masks a Done level still high from the previous run.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      res_z     <= '0;
      res_x     <= '0;
      res_err   <= 1'b0;
      run_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {a, b, c} <= fifo_dout;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + CW'(1);
          if (Done && (wait_cnt >= CW'(MIN_LAT))) begin
            res_z     <= z;
            res_x     <= x;
            res_err   <= 1'b0;
            run_count <= run_count + 16'd1;
            state     <= ST_EMIT;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            res_z   <= '0;
            res_x   <= '0;
            res_err <= 1'b1;
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
